// File: rtl/zerosoc_uart_pkg.sv
// Shared constants, receiver FSM state type and parity helper for the ZeroSoC UART receiver.
// Define ZEROSOC_UART_PARITY_EN to build the PARITY state (8E1 framing).
package zerosoc_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SUB_W      = $clog2(OVERSAMPLE);
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);

  localparam logic [SUB_W-1:0] MID_SAMPLE  = SUB_W'(32'd7);
  localparam logic [SUB_W-1:0] LAST_SAMPLE = SUB_W'(32'd15);
  localparam logic [SUB_W-1:0] SUB_ONE     = SUB_W'(1'b1);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_BITS - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef ZEROSOC_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_rx_state_e;

  // Bit that makes the total number of ones (data plus parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/zerosoc_uart_rx_fifo.sv
// Circular receive buffer with extra-MSB pointers so full and empty are distinguishable.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module zerosoc_uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   lvl_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign lvl_o   = r_wptr - r_rptr;
  assign rdata_o = r_mem[r_rptr[AW-1:0]];

  // Pointer and storage update; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= wdata_i;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/zerosoc_uart_rx.sv
// UART receive front-end: synchronizer, 16x oversampling tick logic, framing FSM and byte FIFO.
// Define ZEROSOC_UART_PARITY_EN for 8E1 frames with a live parity_err_o; otherwise 8N1.
import zerosoc_uart_pkg::*;

module zerosoc_uart_rx #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_i,
  input  logic                   rx_en_i,
  input  logic [DIV_W-1:0]       div_i,
  output logic [7:0]             rdata_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [$clog2(DEPTH):0] fifo_lvl_o,
  output logic                   frame_err_o,
  output logic                   overflow_o,
  output logic                   parity_err_o
);

  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  logic                 w_rx;
  logic                 w_fall;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop_ok;
  logic [DIV_W-1:0]     w_div_m1;
  logic [DIV_W-1:0]     r_tick_cnt;
  uart_rx_state_e       r_state;
  logic [SUB_W-1:0]     r_sub;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_frame_err;
  logic                 r_overflow;
`ifdef ZEROSOC_UART_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
`endif

  assign w_rx     = r_sync2;
  assign w_fall   = r_rx_prev & ~r_sync2;
  assign w_tick   = (r_state != ST_IDLE) && (r_tick_cnt == DIV_ZERO);
  assign w_pop_ok = rready_i & ~w_empty;

  // A divisor of zero behaves like one.
  always_comb begin
    if (div_i == DIV_ZERO) begin
      w_div_m1 = DIV_ZERO;
    end else begin
      w_div_m1 = div_i - DIV_ONE;
    end
  end

`ifdef ZEROSOC_UART_PARITY_EN
  assign w_push = rx_en_i && (r_state == ST_STOP) && w_tick && (r_sub == LAST_SAMPLE)
                  && w_rx && !r_par_bad;
  assign parity_err_o = r_parity_err;
`else
  assign w_push = rx_en_i && (r_state == ST_STOP) && w_tick && (r_sub == LAST_SAMPLE) && w_rx;
  assign parity_err_o = 1'b0;
`endif

  // Synchronizer and edge register all idle high so reset never fakes a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Framing FSM together with its tick/sub-tick counters and error pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= DIV_ZERO;
      r_sub        <= {SUB_W{1'b0}};
      r_bit_idx    <= {IDX_W{1'b0}};
      r_data       <= {DATA_BITS{1'b0}};
      r_frame_err  <= 1'b0;
`ifdef ZEROSOC_UART_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err  <= 1'b0;
`ifdef ZEROSOC_UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (!rx_en_i) begin
        r_state   <= ST_IDLE;
        r_sub     <= {SUB_W{1'b0}};
        r_bit_idx <= {IDX_W{1'b0}};
      end else begin
        if (r_state != ST_IDLE) begin
          if (w_tick) begin
            r_tick_cnt <= w_div_m1;
          end else begin
            r_tick_cnt <= r_tick_cnt - DIV_ONE;
          end
        end
        case (r_state)
          ST_IDLE: begin
            if (w_fall) begin
              r_state    <= ST_START;
              r_tick_cnt <= w_div_m1;
              r_sub      <= {SUB_W{1'b0}};
            end
          end
          // START only waits half a bit, so later samples land mid-bit at LAST_SAMPLE.
          ST_START: begin
            if (w_tick) begin
              if (r_sub == MID_SAMPLE) begin
                r_sub     <= {SUB_W{1'b0}};
                r_bit_idx <= {IDX_W{1'b0}};
                if (w_rx) begin
                  r_state <= ST_IDLE;
                end else begin
                  r_state <= ST_DATA;
                end
              end else begin
                r_sub <= r_sub + SUB_ONE;
              end
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              if (r_sub == LAST_SAMPLE) begin
                r_data[r_bit_idx] <= w_rx;
                r_sub             <= {SUB_W{1'b0}};
                if (r_bit_idx == LAST_BIT) begin
`ifdef ZEROSOC_UART_PARITY_EN
                  r_state <= ST_PARITY;
`else
                  r_state <= ST_STOP;
`endif
                end else begin
                  r_bit_idx <= r_bit_idx + IDX_ONE;
                end
              end else begin
                r_sub <= r_sub + SUB_ONE;
              end
            end
          end
`ifdef ZEROSOC_UART_PARITY_EN
          ST_PARITY: begin
            if (w_tick) begin
              if (r_sub == LAST_SAMPLE) begin
                r_par_bad <= (w_rx != even_parity(r_data));
                r_sub     <= {SUB_W{1'b0}};
                r_state   <= ST_STOP;
              end else begin
                r_sub <= r_sub + SUB_ONE;
              end
            end
          end
`endif
          ST_STOP: begin
            if (w_tick) begin
              if (r_sub == LAST_SAMPLE) begin
                r_frame_err  <= ~w_rx;
`ifdef ZEROSOC_UART_PARITY_EN
                r_parity_err <= r_par_bad;
`endif
                r_sub        <= {SUB_W{1'b0}};
                r_state      <= ST_IDLE;
              end else begin
                r_sub <= r_sub + SUB_ONE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // A push into a full FIFO drops the byte unless a pop frees a slot that same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push & w_full & ~w_pop_ok;
    end
  end

  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_overflow;
  assign rvalid_o    = ~w_empty;

  zerosoc_uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .wdata_i (r_data),
    .pop_i   (rready_i),
    .rdata_o (rdata_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .lvl_o   (fifo_lvl_o)
  );

endmodule

// File: tb/tb_zerosoc_uart_rx.sv
// Directed/randomized bench for zerosoc_uart_rx, checked against a queue-based frame model.
module tb_zerosoc_uart_rx;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
`ifdef ZEROSOC_UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             rx_i;
  logic             rx_en_i;
  logic [DIV_W-1:0] div_i;
  logic [7:0]       rdata_o;
  logic             rvalid_o;
  logic             rready_i;
  logic [3:0]       fifo_lvl_o;
  logic             frame_err_o;
  logic             overflow_o;
  logic             parity_err_o;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int ferr_cnt = 0, ovf_cnt = 0, perr_cnt = 0;
  int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
  int t_fall = 0, t_push = 0;
  logic [3:0] prev_lvl = 4'd0;
  logic [7:0] q[$];

  zerosoc_uart_rx #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .rx_en_i      (rx_en_i),
    .div_i        (div_i),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i),
    .fifo_lvl_o   (fifo_lvl_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Counts cycles each pulse output is high and notes when occupancy rises.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (frame_err_o)  ferr_cnt <= ferr_cnt + 1;
      if (overflow_o)   ovf_cnt  <= ovf_cnt + 1;
      if (parity_err_o) perr_cnt <= perr_cnt + 1;
      if (fifo_lvl_o > prev_lvl) t_push <= cyc;
    end
    prev_lvl <= fifo_lvl_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_period();
    return 16 * ((div_i == 16'd0) ? 1 : int'(div_i));
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drive one frame; the model decides what the receiver should do with it.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input int drop_bit, input logic pop_at_push);
    int bp;
    bp = bit_period();
    @(posedge clk_i); #1;
    rx_i   = 1'b0;
    t_fall = cyc;
    wait_cycles(bp);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_bit) rx_en_i = 1'b0;
      rx_i = d[i];
      wait_cycles(bp);
    end
    if (PAR_BITS == 1) begin
      rx_i = (^d) ^ par_flip;
      wait_cycles(bp);
    end
    rx_i = stop_b;
    if (pop_at_push) begin
      // The stop sample lands half a bit in, 3 cycles of detect latency after the edge.
      wait_cycles(bp / 2 + 2);
      check("head_before_pop", {24'd0, rdata_o}, {24'd0, q[0]});
      rready_i = 1'b1;
      wait_cycles(1);
      rready_i = 1'b0;
      void'(q.pop_front());
      wait_cycles(bp - bp / 2 - 3);
    end else begin
      wait_cycles(bp);
    end
    rx_i = 1'b1;
    wait_cycles(2 * bp);
    if (drop_bit < 0) begin
      if (!stop_b) exp_ferr++;
      if (par_flip && PAR_BITS == 1) exp_perr++;
      if (stop_b && !(par_flip && PAR_BITS == 1)) begin
        if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf++;
      end
    end
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk_i);
    check("rvalid_before_pop", {31'd0, rvalid_o}, 32'd1);
    check("lvl_before_pop", {28'd0, fifo_lvl_o}, q.size());
    check(tag, {24'd0, rdata_o}, {24'd0, q[0]});
    rready_i = 1'b1;
    @(posedge clk_i); #1;
    rready_i = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_one(tag);
    @(negedge clk_i);
    check("rvalid_after_drain", {31'd0, rvalid_o}, 32'd0);
    check("lvl_after_drain", {28'd0, fifo_lvl_o}, 32'd0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    check({tag, "_ovf"},  ovf_cnt,  exp_ovf);
    check({tag, "_perr"}, perr_cnt, exp_perr);
  endtask

  initial begin
    int lat, lo;
    logic [7:0] rb;
    rst_ni = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1; rready_i = 1'b0; div_i = 16'd4;
    wait_cycles(5);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_lvl", {28'd0, fifo_lvl_o}, 32'd0);
    check("rst_rdata", {24'd0, rdata_o}, 32'd0);
    check("rst_pulses", {29'd0, frame_err_o, overflow_o, parity_err_o}, 32'd0);

    // Single byte with latency bound.
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0);
    lat = t_push - t_fall;
    lo  = bit_period() * (19 + 2 * PAR_BITS) / 2;
    check("latency_min", {31'd0, lat >= lo}, 32'd1);
    check("latency_max", {31'd0, lat <= lo + 4}, 32'd1);
    check_flags("single");
    drain("single_byte");

    // Short start glitch is rejected, then a normal byte still gets through.
    @(posedge clk_i); #1;
    rx_i = 1'b0;
    wait_cycles(20);
    rx_i = 1'b1;
    wait_cycles(3 * bit_period());
    check("glitch_lvl", {28'd0, fifo_lvl_o}, 32'd0);
    check_flags("glitch");
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, 1'b1, 1'b0, -1, 1'b0);
    drain("after_glitch");

    // Framing error followed by a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
    check("ferr_lvl", {28'd0, fifo_lvl_o}, 32'd0);
    check_flags("frame_err");
    send_frame(8'h55, 1'b1, 1'b0, -1, 1'b0);
    drain("after_ferr");

    // Overflow on the ninth byte.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, -1, 1'b0);
    check("ovf_lvl", {28'd0, fifo_lvl_o}, 32'd8);
    check_flags("overflow");
    drain("ovf_order");

    // Refill with random bytes, then push and pop on the same edge while full.
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, 1'b0);
    check("full_lvl", {28'd0, fifo_lvl_o}, 32'd8);
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, 1'b1);
    check("full_pop_lvl", {28'd0, fifo_lvl_o}, 32'd8);
    check_flags("full_pop");
    drain("full_pop_order");

    // Enable removed mid-DATA discards the byte; the next byte is received.
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 4, 1'b0);
    check("drop_lvl", {28'd0, fifo_lvl_o}, 32'd0);
    rx_en_i = 1'b1;
    wait_cycles(4);
    check_flags("drop");
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, 1'b0);
    drain("after_drop");

    // Divisor 0 behaves as 1.
    div_i = 16'd0;
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, 1'b0);
    lat = t_push - t_fall;
    lo  = 16 * (19 + 2 * PAR_BITS) / 2;
    check("div0_latency", {31'd0, (lat >= lo) && (lat <= lo + 4)}, 32'd1);
    drain("div0");
    div_i = 16'd4;

`ifdef ZEROSOC_UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
    check("par_bad_lvl", {28'd0, fifo_lvl_o}, 32'd0);
    check_flags("parity_bad");
    send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
    drain("parity_good");
`endif

    check_flags("final");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
